// File: rtl/spi_slave_reg_ctrl.sv
// Register-access front end for a byte-oriented SPI slave: command byte, then write or read data bytes.
// Define SPI_REGCTRL_FRAMECNT_EN to report a completed-frame counter as the status byte instead of 8'hA5.
module spi_slave_reg_ctrl #(
  parameter int DATAWIDTH_BUS = 8,
  parameter int ADDR_WIDTH    = 4
) (
  input  logic                     SPI_REGCTRL_CLOCK_50,
  input  logic                     SPI_REGCTRL_RESET_InHigh,
  input  logic                     SPI_REGCTRL_SS_InLow,
  input  logic                     SPI_REGCTRL_newData_In,
  input  logic [DATAWIDTH_BUS-1:0] SPI_REGCTRL_data_In,
  output logic [DATAWIDTH_BUS-1:0] SPI_REGCTRL_txData_Out,
  output logic [ADDR_WIDTH-1:0]    SPI_REGCTRL_regAddr_Out,
  output logic                     SPI_REGCTRL_regWrite_Out,
  output logic [DATAWIDTH_BUS-1:0] SPI_REGCTRL_regWdata_Out,
  output logic                     SPI_REGCTRL_regRead_Out,
  input  logic [DATAWIDTH_BUS-1:0] SPI_REGCTRL_regRdata_In
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CMD      = 3'd1;
  localparam logic [2:0] ST_RD_FETCH = 3'd2;
  localparam logic [2:0] ST_RD_CAP   = 3'd3;
  localparam logic [2:0] ST_RD_WAIT  = 3'd4;
  localparam logic [2:0] ST_WR_DATA  = 3'd5;

  logic [2:0]               state_q, state_d;
  logic                     ss_q, ss_d;
  logic [ADDR_WIDTH-1:0]    cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0]    reg_addr_q, reg_addr_d;
  logic                     auto_inc_q, auto_inc_d;
  logic                     write_q, write_d;
  logic                     read_q, read_d;
  logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;
  logic [DATAWIDTH_BUS-1:0] tx_q, tx_d;
  logic [DATAWIDTH_BUS-1:0] status;
  logic [ADDR_WIDTH-1:0]    addr_next;

`ifdef SPI_REGCTRL_FRAMECNT_EN
  localparam logic [DATAWIDTH_BUS-1:0] STATUS_RST = '0;

  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       frame_end;

  // A frame counts once its command byte was taken, i.e. any exit to IDLE except a bare abort from CMD.
  always_comb begin
    frame_end   = (state_q != ST_IDLE) && (state_d == ST_IDLE) &&
                  ((state_q != ST_CMD) || SPI_REGCTRL_newData_In);
    frame_cnt_d = frame_cnt_q + {7'd0, frame_end};
  end

  always_ff @(posedge SPI_REGCTRL_CLOCK_50) begin
    if (SPI_REGCTRL_RESET_InHigh) frame_cnt_q <= 8'd0;
    else                          frame_cnt_q <= frame_cnt_d;
  end

  assign status = frame_cnt_q;
`else
  localparam logic [DATAWIDTH_BUS-1:0] STATUS_RST = 8'hA5;

  assign status = STATUS_RST;
`endif

  assign ss_d      = SPI_REGCTRL_SS_InLow;
  assign addr_next = cur_addr_q + {{(ADDR_WIDTH-1){1'b0}}, auto_inc_q};

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    reg_addr_d = reg_addr_q;
    auto_inc_d = auto_inc_q;
    write_d    = 1'b0;
    read_d     = 1'b0;
    wdata_d    = wdata_q;
    tx_d       = tx_q;

    case (state_q)
      ST_IDLE: begin
        tx_d = status;
        if (!ss_q) state_d = ST_CMD;
      end

      ST_CMD: begin
        tx_d = status;
        if (SPI_REGCTRL_newData_In) begin
          cur_addr_d = SPI_REGCTRL_data_In[ADDR_WIDTH-1:0];
          reg_addr_d = SPI_REGCTRL_data_In[ADDR_WIDTH-1:0];
          auto_inc_d = SPI_REGCTRL_data_In[6];
          if (ss_q) begin
            state_d = ST_IDLE;
          end else if (SPI_REGCTRL_data_In[7]) begin
            state_d = ST_RD_FETCH;
            read_d  = 1'b1;
          end else begin
            state_d = ST_WR_DATA;
          end
        end else if (ss_q) begin
          state_d = ST_IDLE;
        end
      end

      ST_RD_FETCH: state_d = ss_q ? ST_IDLE : ST_RD_CAP;

      ST_RD_CAP: begin
        if (ss_q) begin
          state_d = ST_IDLE;
        end else begin
          tx_d    = SPI_REGCTRL_regRdata_In;
          state_d = ST_RD_WAIT;
        end
      end

      // The fetch launched here supplies the byte after next, hence the one-byte read lag.
      ST_RD_WAIT: begin
        if (ss_q) begin
          state_d = ST_IDLE;
        end else if (SPI_REGCTRL_newData_In) begin
          cur_addr_d = addr_next;
          reg_addr_d = addr_next;
          read_d     = 1'b1;
          state_d    = ST_RD_FETCH;
        end
      end

      ST_WR_DATA: begin
        tx_d = status;
        if (SPI_REGCTRL_newData_In) begin
          write_d    = 1'b1;
          wdata_d    = SPI_REGCTRL_data_In;
          reg_addr_d = cur_addr_q;
          cur_addr_d = addr_next;
        end
        if (ss_q) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SPI_REGCTRL_CLOCK_50) begin
    if (SPI_REGCTRL_RESET_InHigh) begin
      state_q    <= ST_IDLE;
      ss_q       <= 1'b1;
      cur_addr_q <= '0;
      reg_addr_q <= '0;
      auto_inc_q <= 1'b0;
      write_q    <= 1'b0;
      read_q     <= 1'b0;
      wdata_q    <= '0;
      tx_q       <= STATUS_RST;
    end else begin
      state_q    <= state_d;
      ss_q       <= ss_d;
      cur_addr_q <= cur_addr_d;
      reg_addr_q <= reg_addr_d;
      auto_inc_q <= auto_inc_d;
      write_q    <= write_d;
      read_q     <= read_d;
      wdata_q    <= wdata_d;
      tx_q       <= tx_d;
    end
  end

  assign SPI_REGCTRL_txData_Out   = tx_q;
  assign SPI_REGCTRL_regAddr_Out  = reg_addr_q;
  assign SPI_REGCTRL_regWrite_Out = write_q;
  assign SPI_REGCTRL_regWdata_Out = wdata_q;
  assign SPI_REGCTRL_regRead_Out  = read_q;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Self-checking bench for spi_slave_reg_ctrl: directed frames plus random frames against a frame-level model.
// Build with SPI_REGCTRL_FRAMECNT_EN defined to exercise the frame-counter status byte.
module tb_spi_slave_reg_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss  = 1'b1;
  logic       nd  = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] rdata = 8'h00;
  logic [7:0] tx;
  logic [3:0] raddr;
  logic       wr;
  logic [7:0] wdata;
  logic       rd;

  always #5 clk = ~clk;

  spi_slave_reg_ctrl #(.DATAWIDTH_BUS(8), .ADDR_WIDTH(4)) dut (
    .SPI_REGCTRL_CLOCK_50     (clk),
    .SPI_REGCTRL_RESET_InHigh (rst),
    .SPI_REGCTRL_SS_InLow     (ss),
    .SPI_REGCTRL_newData_In   (nd),
    .SPI_REGCTRL_data_In      (din),
    .SPI_REGCTRL_txData_Out   (tx),
    .SPI_REGCTRL_regAddr_Out  (raddr),
    .SPI_REGCTRL_regWrite_Out (wr),
    .SPI_REGCTRL_regWdata_Out (wdata),
    .SPI_REGCTRL_regRead_Out  (rd),
    .SPI_REGCTRL_regRdata_In  (rdata)
  );

`ifdef SPI_REGCTRL_FRAMECNT_EN
  localparam bit         CNT_EN     = 1'b1;
  localparam logic [7:0] STATUS_RST = 8'h00;
`else
  localparam bit         CNT_EN     = 1'b0;
  localparam logic [7:0] STATUS_RST = 8'hA5;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int frames_done = 0;

  logic [7:0] bank [16];
  logic [7:0] payload [$];
  logic [3:0] mon_wr_addr [$];
  logic [7:0] mon_wr_data [$];
  bit         mon_wr_lag  [$];
  logic [3:0] mon_rd_addr [$];
  logic [7:0] tx_log      [$];
  int         dbl_strobe = 0;
  logic [3:0] exp_wr_addr [$];
  logic [7:0] exp_wr_data [$];
  logic [3:0] exp_rd_addr [$];
  logic [7:0] exp_tx      [$];
  bit nd_at_edge = 1'b0;
  bit prev_wr = 1'b0;
  bit prev_rd = 1'b0;

  // Register bank responder: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (rd) rdata <= bank[raddr];
  end

  always @(posedge clk) nd_at_edge = nd;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wr) begin
      mon_wr_addr.push_back(raddr);
      mon_wr_data.push_back(wdata);
      mon_wr_lag.push_back(nd_at_edge);
    end
    if (rd) mon_rd_addr.push_back(raddr);
    if ((wr && prev_wr) || (rd && prev_rd)) dbl_strobe++;
    prev_wr = wr;
    prev_rd = rd;
  end

  function automatic logic [7:0] status_model();
    return CNT_EN ? 8'(frames_done) : 8'hA5;
  endfunction

  // Frame-level expectations: which writes, which fetches, and which byte goes out in each slot.
  function automatic void model_frame(input logic [7:0] cmd, input int n, input bit last_sim);
    logic [3:0] start = cmd[3:0];
    int         step  = cmd[6] ? 1 : 0;
    logic [7:0] st    = status_model();
    int         nf;
    exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete(); exp_tx.delete();
    if (!cmd[7]) begin
      for (int i = 0; i < n; i++) begin
        exp_wr_addr.push_back(4'(start + i * step));
        exp_wr_data.push_back(payload[i]);
      end
      for (int i = 0; i <= n; i++) exp_tx.push_back(st);
    end else begin
      nf = last_sim ? n : n + 1;
      for (int j = 0; j < nf; j++) exp_rd_addr.push_back(4'(start + j * step));
      for (int k = 1; k <= n; k++)
        exp_tx.push_back((k == 1) ? st : bank[4'(start + (k - 2) * step)]);
    end
    frames_done++;
  endfunction

  task automatic clear_monitor();
    @(posedge clk); #1;
    mon_wr_addr.delete(); mon_wr_data.delete(); mon_wr_lag.delete();
    mon_rd_addr.delete(); tx_log.delete(); dbl_strobe = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit end_with);
    repeat ($urandom_range(10, 6)) @(negedge clk);
    if (end_with) begin
      ss = 1'b1;
      @(negedge clk);
    end
    nd = 1'b1;
    din = b;
    tx_log.push_back(tx);
    @(negedge clk);
    nd = 1'b0;
    din = 8'($urandom);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input int n, input bit last_sim);
    clear_monitor();
    @(negedge clk);
    ss = 1'b0;
    send_byte(cmd, last_sim && (n == 0));
    for (int i = 0; i < n; i++) send_byte(payload[i], last_sim && (i == n - 1));
    if (!last_sim) begin
      repeat (8) @(negedge clk);
      ss = 1'b1;
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ss  = 1'b1;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (raddr !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_addr: got %0h want 0", raddr); end
    if (wr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_wr: got %0b want 0", wr); end
    if (rd !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd: got %0b want 0", rd); end
    if (wdata !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_wdata: got %0h want 0", wdata); end
    if (tx !== STATUS_RST) begin n_fail++; $display("[TB] FAIL reset_tx: got %0h want %0h", tx, STATUS_RST); end
    rst = 1'b0;
    frames_done = 0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (tx !== STATUS_RST) begin n_fail++; $display("[TB] FAIL idle_tx_after_reset: got %0h want %0h", tx, STATUS_RST); end
  endtask

  task automatic test_write_auto_inc();
    payload = '{8'h11, 8'h22};
    model_frame(8'h43, 2, 1'b0);
    run_frame(8'h43, 2, 1'b0);
    n_checks++;
    if (mon_wr_addr.size() != 2) begin
      n_fail++; $display("[TB] FAIL write_count: got %0d want 2", mon_wr_addr.size());
    end else begin
      n_checks += 5;
      if (mon_wr_addr[0] !== 4'd3) begin n_fail++; $display("[TB] FAIL write0_addr: got %0h want 3", mon_wr_addr[0]); end
      if (mon_wr_data[0] !== 8'h11) begin n_fail++; $display("[TB] FAIL write0_data: got %0h want 11", mon_wr_data[0]); end
      if (mon_wr_addr[1] !== 4'd4) begin n_fail++; $display("[TB] FAIL write1_addr: got %0h want 4", mon_wr_addr[1]); end
      if (mon_wr_data[1] !== 8'h22) begin n_fail++; $display("[TB] FAIL write1_data: got %0h want 22", mon_wr_data[1]); end
      if (!(mon_wr_lag[0] && mon_wr_lag[1])) begin n_fail++; $display("[TB] FAIL write_latency: got %0b%0b want 11", mon_wr_lag[0], mon_wr_lag[1]); end
    end
    n_checks += 3;
    if (mon_rd_addr.size() != 0) begin n_fail++; $display("[TB] FAIL write_no_read: got %0d want 0", mon_rd_addr.size()); end
    if (dbl_strobe != 0) begin n_fail++; $display("[TB] FAIL write_strobe_width: got %0d want 0", dbl_strobe); end
    if (tx !== status_model()) begin n_fail++; $display("[TB] FAIL write_idle_tx: got %0h want %0h", tx, status_model()); end
  endtask

  task automatic test_read_auto_inc();
    logic [7:0] st0;
    bank[5] = 8'h5A;
    bank[6] = 8'h6B;
    payload = '{8'h00, 8'h00, 8'h00};
    st0 = status_model();
    model_frame(8'hC5, 3, 1'b1);
    run_frame(8'hC5, 3, 1'b1);
    n_checks++;
    if (mon_rd_addr.size() != 3) begin
      n_fail++; $display("[TB] FAIL read_count: got %0d want 3", mon_rd_addr.size());
    end else begin
      n_checks += 3;
      if (mon_rd_addr[0] !== 4'd5) begin n_fail++; $display("[TB] FAIL read0_addr: got %0h want 5", mon_rd_addr[0]); end
      if (mon_rd_addr[1] !== 4'd6) begin n_fail++; $display("[TB] FAIL read1_addr: got %0h want 6", mon_rd_addr[1]); end
      if (mon_rd_addr[2] !== 4'd7) begin n_fail++; $display("[TB] FAIL read2_addr: got %0h want 7", mon_rd_addr[2]); end
    end
    n_checks++;
    if (tx_log.size() != 4) begin
      n_fail++; $display("[TB] FAIL read_tx_slots: got %0d want 4", tx_log.size());
    end else begin
      n_checks += 3;
      if (tx_log[0] !== st0) begin n_fail++; $display("[TB] FAIL read_tx_byte1: got %0h want %0h", tx_log[0], st0); end
      if (tx_log[1] !== 8'h5A) begin n_fail++; $display("[TB] FAIL read_tx_byte2: got %0h want 5a", tx_log[1]); end
      if (tx_log[2] !== 8'h6B) begin n_fail++; $display("[TB] FAIL read_tx_byte3: got %0h want 6b", tx_log[2]); end
    end
    n_checks += 2;
    if (mon_wr_addr.size() != 0) begin n_fail++; $display("[TB] FAIL read_no_write: got %0d want 0", mon_wr_addr.size()); end
    if (dbl_strobe != 0) begin n_fail++; $display("[TB] FAIL read_strobe_width: got %0d want 0", dbl_strobe); end
  endtask

  task automatic test_wrap();
    payload = '{8'($urandom), 8'($urandom), 8'($urandom)};
    model_frame(8'h4F, 3, 1'b0);
    run_frame(8'h4F, 3, 1'b0);
    n_checks++;
    if (mon_wr_addr.size() != 3) begin
      n_fail++; $display("[TB] FAIL wrap_count: got %0d want 3", mon_wr_addr.size());
    end else begin
      n_checks += 4;
      if (mon_wr_addr[0] !== 4'd15) begin n_fail++; $display("[TB] FAIL wrap0_addr: got %0h want f", mon_wr_addr[0]); end
      if (mon_wr_addr[1] !== 4'd0) begin n_fail++; $display("[TB] FAIL wrap1_addr: got %0h want 0", mon_wr_addr[1]); end
      if (mon_wr_addr[2] !== 4'd1) begin n_fail++; $display("[TB] FAIL wrap2_addr: got %0h want 1", mon_wr_addr[2]); end
      if (mon_wr_data[2] !== payload[2]) begin n_fail++; $display("[TB] FAIL wrap2_data: got %0h want %0h", mon_wr_data[2], payload[2]); end
    end
  endtask

  task automatic test_abort();
    clear_monitor();
    @(negedge clk);
    ss = 1'b0;
    send_byte(8'h41, 1'b0);
    repeat (5) @(negedge clk);
    ss = 1'b1;
    frames_done++;
    repeat (4) @(negedge clk);
    nd = 1'b1;
    din = 8'hEE;
    @(negedge clk);
    nd = 1'b0;
    repeat (3) @(negedge clk);
    ss = 1'b0;
    repeat (4) @(negedge clk);
    ss = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    n_checks += 2;
    if (mon_wr_addr.size() != 0) begin n_fail++; $display("[TB] FAIL abort_no_write: got %0d want 0", mon_wr_addr.size()); end
    if (tx !== status_model()) begin n_fail++; $display("[TB] FAIL abort_idle_tx: got %0h want %0h", tx, status_model()); end
    payload = '{8'h33};
    model_frame(8'h47, 1, 1'b0);
    run_frame(8'h47, 1, 1'b0);
    n_checks++;
    if (mon_wr_addr.size() != 1) begin
      n_fail++; $display("[TB] FAIL after_abort_count: got %0d want 1", mon_wr_addr.size());
    end else begin
      n_checks += 2;
      if (mon_wr_addr[0] !== 4'd7) begin n_fail++; $display("[TB] FAIL after_abort_addr: got %0h want 7", mon_wr_addr[0]); end
      if (mon_wr_data[0] !== 8'h33) begin n_fail++; $display("[TB] FAIL after_abort_data: got %0h want 33", mon_wr_data[0]); end
    end
    n_checks++;
    if (tx !== status_model()) begin n_fail++; $display("[TB] FAIL after_abort_tx: got %0h want %0h", tx, status_model()); end
  endtask

  task automatic test_simultaneous();
    payload = '{8'h77};
    model_frame(8'h02, 1, 1'b1);
    run_frame(8'h02, 1, 1'b1);
    n_checks++;
    if (mon_wr_addr.size() != 1) begin
      n_fail++; $display("[TB] FAIL simul_count: got %0d want 1", mon_wr_addr.size());
    end else begin
      n_checks += 2;
      if (mon_wr_addr[0] !== 4'd2) begin n_fail++; $display("[TB] FAIL simul_addr: got %0h want 2", mon_wr_addr[0]); end
      if (mon_wr_data[0] !== 8'h77) begin n_fail++; $display("[TB] FAIL simul_data: got %0h want 77", mon_wr_data[0]); end
    end
    n_checks++;
    if (tx !== status_model()) begin n_fail++; $display("[TB] FAIL simul_idle_tx: got %0h want %0h", tx, status_model()); end
  endtask

  task automatic test_random_frames();
    logic [7:0] cmd;
    int         n;
    bit         last_sim;
    for (int f = 0; f < 12; f++) begin
      cmd = 8'($urandom);
      n = int'($urandom_range(4, 0));
      last_sim = bit'($urandom_range(1, 0));
      payload.delete();
      for (int i = 0; i < n; i++) payload.push_back(8'($urandom));
      model_frame(cmd, n, last_sim);
      run_frame(cmd, n, last_sim);
      n_checks += 3;
      if (mon_wr_addr.size() != exp_wr_addr.size()) begin
        n_fail++; $display("[TB] FAIL rand%0d_wr_count: got %0d want %0d", f, mon_wr_addr.size(), exp_wr_addr.size());
      end else begin
        foreach (exp_wr_addr[i]) begin
          n_checks++;
          if (mon_wr_addr[i] !== exp_wr_addr[i] || mon_wr_data[i] !== exp_wr_data[i] || !mon_wr_lag[i]) begin
            n_fail++;
            $display("[TB] FAIL rand%0d_write%0d: got %0h/%0h lag %0b want %0h/%0h lag 1", f, i,
                     mon_wr_addr[i], mon_wr_data[i], mon_wr_lag[i], exp_wr_addr[i], exp_wr_data[i]);
          end
        end
      end
      if (mon_rd_addr.size() != exp_rd_addr.size()) begin
        n_fail++; $display("[TB] FAIL rand%0d_rd_count: got %0d want %0d", f, mon_rd_addr.size(), exp_rd_addr.size());
      end else begin
        foreach (exp_rd_addr[i]) begin
          n_checks++;
          if (mon_rd_addr[i] !== exp_rd_addr[i]) begin
            n_fail++; $display("[TB] FAIL rand%0d_read%0d: got %0h want %0h", f, i, mon_rd_addr[i], exp_rd_addr[i]);
          end
        end
      end
      if (tx_log.size() < exp_tx.size()) begin
        n_fail++; $display("[TB] FAIL rand%0d_tx_slots: got %0d want %0d", f, tx_log.size(), exp_tx.size());
      end else begin
        foreach (exp_tx[i]) begin
          n_checks++;
          if (tx_log[i] !== exp_tx[i]) begin
            n_fail++; $display("[TB] FAIL rand%0d_tx%0d: got %0h want %0h", f, i, tx_log[i], exp_tx[i]);
          end
        end
      end
      n_checks += 2;
      if (dbl_strobe != 0) begin n_fail++; $display("[TB] FAIL rand%0d_strobe_width: got %0d want 0", f, dbl_strobe); end
      if (tx !== status_model()) begin n_fail++; $display("[TB] FAIL rand%0d_idle_tx: got %0h want %0h", f, tx, status_model()); end
    end
  endtask

  task automatic test_reset_mid_read();
    clear_monitor();
    @(negedge clk);
    ss = 1'b0;
    send_byte(8'hC3, 1'b0);
    send_byte(8'h00, 1'b0);
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks += 4;
      if (wr !== 1'b0 || rd !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset%0d_strobes: got wr%0b rd%0b want 00", c, wr, rd); end
      if (tx !== STATUS_RST) begin n_fail++; $display("[TB] FAIL midreset%0d_tx: got %0h want %0h", c, tx, STATUS_RST); end
      if (raddr !== 4'h0) begin n_fail++; $display("[TB] FAIL midreset%0d_addr: got %0h want 0", c, raddr); end
      if (wdata !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset%0d_wdata: got %0h want 0", c, wdata); end
    end
    ss = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frames_done = 0;
    clear_monitor();
    repeat (8) @(negedge clk);
    @(posedge clk); #1;
    n_checks += 2;
    if (mon_wr_addr.size() + mon_rd_addr.size() != 0) begin
      n_fail++; $display("[TB] FAIL after_midreset_strobes: got %0d want 0", mon_wr_addr.size() + mon_rd_addr.size());
    end
    if (tx !== STATUS_RST) begin n_fail++; $display("[TB] FAIL after_midreset_tx: got %0h want %0h", tx, STATUS_RST); end
  endtask

  task automatic test_frame_count();
    logic [7:0] want;
    payload = '{8'h5C};
    model_frame(8'h40, 1, 1'b0);
    run_frame(8'h40, 1, 1'b0);
    model_frame(8'h80, 1, 1'b0);
    run_frame(8'h80, 1, 1'b0);
    want = CNT_EN ? 8'h02 : 8'hA5;
    n_checks++;
    if (tx !== want) begin n_fail++; $display("[TB] FAIL two_frame_status: got %0h want %0h", tx, want); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bank[i] = 8'($urandom);
    test_reset();
    test_write_auto_inc();
    test_read_auto_inc();
    test_wrap();
    test_abort();
    test_simultaneous();
    test_random_frames();
    test_reset_mid_read();
    test_frame_count();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_reg_ctrl.md
SPI_SLAVE_REG_CTRL -- requirements
Module: spi_slave_reg_ctrl

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 8: byte width exchanged with the SPI slave; only 8 is supported.
REQ-002 Parameter ADDR_WIDTH, default 4: register address width, giving 16 registers.
REQ-003 SPI_REGCTRL_CLOCK_50  in  1  system clock; all logic is on its rising edge.
REQ-004 SPI_REGCTRL_RESET_InHigh  in  1  reset, synchronous, active-high.
REQ-005 SPI_REGCTRL_SS_InLow  in  1  slave select, low = frame active; registered once internally.
REQ-006 SPI_REGCTRL_newData_In  in  1  one-cycle pulse from the SPI slave when a received byte is complete.
REQ-007 SPI_REGCTRL_data_In  in  8  received byte; valid while newData_In is high.
REQ-008 SPI_REGCTRL_txData_Out  out  8  next byte to transmit; drives the SPI slave data input.
REQ-009 SPI_REGCTRL_regAddr_Out  out  ADDR_WIDTH  register address.
REQ-010 SPI_REGCTRL_regWrite_Out  out  1  one-cycle write strobe.
REQ-011 SPI_REGCTRL_regWdata_Out  out  8  write data; valid while regWrite_Out is high.
REQ-012 SPI_REGCTRL_regRead_Out  out  1  one-cycle read strobe.
REQ-013 SPI_REGCTRL_regRdata_In  in  8  read data; valid in the cycle after regRead_Out is high.

Function
REQ-014 Frame format: byte 0 is the command; bit7 = 1 read / 0 write, bit6 = auto-increment, bits3:0 = start address, bits5:4 ignored.
REQ-015 States: IDLE, CMD, RD_FETCH, RD_CAP, RD_WAIT, WR_DATA; all outputs are registered.
REQ-016 IDLE: registered SS high; enter CMD when registered SS is low.
REQ-017 CMD: on newData_In, latch rw, auto-increment and address; go to RD_FETCH if read, else WR_DATA.
REQ-018 RD_FETCH: regRead_Out high for exactly one cycle with regAddr_Out = current address; then go to RD_CAP.
REQ-019 RD_CAP: capture regRdata_In into txData_Out; then go to RD_WAIT.
REQ-020 RD_WAIT: on newData_In, advance the address if auto-increment is set, then go to RD_FETCH.
REQ-021 Read timing: newData_In high in cycle N gives regRead_Out high in N+1 and the new txData_Out from N+3.
REQ-022 Read data lags by one byte: byte 1 of a read frame carries the status byte, and byte k (k>=2) carries reg[start + (k-2)] when auto-increment is set, or reg[start] when it is not.
REQ-023 WR_DATA: on newData_In in cycle N, regWrite_Out is high in N+1 with regWdata_Out = data_In and regAddr_Out = current address.
REQ-024 WR_DATA: after each write, advance the address if auto-increment is set.
REQ-025 Address increment wraps from 15 to 0.
REQ-026 txData_Out holds the status byte in IDLE, in CMD, throughout write frames, and on entry to a read frame until the first RD_CAP.
REQ-027 Registered SS high in any non-IDLE state: abort and go to IDLE next cycle; no strobe is issued for an incomplete byte.
REQ-028 newData_In and registered SS high in the same cycle: the byte is processed first (write strobe, or address latch for a command), then go to IDLE; no read fetch is started.
REQ-029 newData_In in IDLE is ignored.
REQ-030 newData_In in RD_FETCH or RD_CAP is ignored, because SCK byte time far exceeds 3 clocks.

Reset
REQ-031 While reset is high at a clock edge: state = IDLE, regAddr_Out = 0, regWrite_Out = 0, regRead_Out = 0, regWdata_Out = 0, txData_Out = status reset value, frame counter = 0, SS register = 1.
REQ-032 Reset mid-frame discards the transaction with no strobe; normal operation resumes at the first edge after reset deasserts.

Configuration
REQ-033 Macro SPI_REGCTRL_FRAMECNT_EN defined: an 8-bit frame counter increments on each return to IDLE from a frame that completed its command byte, wrapping 255 to 0.
REQ-034 With the macro defined, the status byte is the frame counter value, and its reset value is 8'h00.
REQ-035 Macro undefined: no counter is built, and the status byte is constant 8'hA5, including at reset.

Verification
REQ-036 Write frame: cmd 8'h43, data 8'h11, 8'h22 -> regWrite at addr 3 with 8'h11, then at addr 4 with 8'h22; each strobe is 1 cycle, 1 cycle after newData_In.
REQ-037 Read frame: cmd 8'hC5, three more bytes, bank reg5=8'h5A, reg6=8'h6B -> tx bytes 1..3 = status, 8'h5A, 8'h6B; regRead strobed at addr 5, 6, 7.
REQ-038 Wrap: cmd 8'h4F, three data bytes -> writes at addr 15, 0, 1.
REQ-039 Abort: SS raised after 4 of 8 bits of byte 1 of a write frame -> no regWrite, IDLE next cycle; a following frame operates normally.
REQ-040 Simultaneous: newData_In with data 8'h77 and SS rising in the same cycle in WR_DATA at addr 2 -> single write of 8'h77 at addr 2, then IDLE.
REQ-041 Config: two completed frames with SPI_REGCTRL_FRAMECNT_EN -> IDLE txData_Out = 8'h02; without it -> 8'hA5; reset mid-read -> all strobes 0, txData_Out at status reset value.
